// File: rtl/stage2_regfile_expand.sv
// Decode-stage register file: 32 x 32-bit, two read ports, one write port.
// Also holds a combinational 32->64-bit sign-extension unit.
module stage2_regfile_expand #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int EXT_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic              writeEnable,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] inData,
  output logic [EXT_W-1:0]  outData
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              doWrite;

  assign doWrite = writeEnable && (writeReg != '0);

  // Synchronous clear, then write-back; x0 never takes a write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (doWrite) begin
      regs[writeReg] <= writeData;
    end
  end

  // Zero-latency reads, x0 forced to zero, no write bypass.
  always_comb begin
    data1 = '0;
    data2 = '0;
    if (readReg1 != '0) data1 = regs[readReg1];
    if (readReg2 != '0) data2 = regs[readReg2];
  end

  // Replicate the operand sign bit into the upper bits.
  always_comb begin
    outData = {{(EXT_W-DATA_W){inData[DATA_W-1]}}, inData};
  end

endmodule

// File: tb/tb_stage2_regfile_expand.sv
// Scoreboard bench for stage2_regfile_expand.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_stage2_regfile_expand;

  logic        clk;
  logic        rst_n;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [4:0]  writeReg;
  logic        writeEnable;
  logic [31:0] writeData;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] inData;
  logic [63:0] outData;

  stage2_regfile_expand dut (
    .clk(clk),
    .rst_n(rst_n),
    .readReg1(readReg1),
    .readReg2(readReg2),
    .writeReg(writeReg),
    .writeEnable(writeEnable),
    .writeData(writeData),
    .data1(data1),
    .data2(data2),
    .inData(inData),
    .outData(outData)
  );

  typedef struct {
    int          kind;
    logic [63:0] exp;
    string       name;
  } sbEntry_t;

  sbEntry_t    sbq[$];
  int          errors = 0;
  int          checks = 0;
  bit   [31:0] model[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every negedge, compare all expectations queued for this cycle.
  initial begin
    sbEntry_t e;
    logic [63:0] act;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        case (e.kind)
          0:       act = {32'h0, data1};
          1:       act = {32'h0, data2};
          default: act = outData;
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h at %0t",
                   e.name, act, e.exp, $time);
        end
      end
    end
  end

  function automatic logic [63:0] sext(input logic [31:0] x);
    longint v;
    v = longint'(int'(x));
    return 64'(v);
  endfunction

  task automatic push(input int kind, input logic [63:0] exp,
                      input string name);
    sbEntry_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sbq.push_back(e);
  endtask

  // Drive one cycle; expectations reflect the model before the edge.
  task automatic drive(input bit rn, input bit we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [31:0] ind,
                       input bit chk, input string tag);
    rst_n       = rn;
    writeEnable = we;
    writeReg    = wr;
    writeData   = wd;
    readReg1    = r1;
    readReg2    = r2;
    inData      = ind;
    if (chk) begin
      push(0, {32'h0, (r1 == 0) ? 32'h0 : model[r1]}, {tag, ".data1"});
      push(1, {32'h0, (r2 == 0) ? 32'h0 : model[r2]}, {tag, ".data2"});
    end
    push(2, sext(ind), {tag, ".outData"});
    @(posedge clk);
    if (!rn) begin
      foreach (model[i]) model[i] = 32'h0;
    end else if (we && wr != 0) begin
      model[wr] = wd;
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    writeEnable = 1'b0;
    writeReg = '0;
    writeData = '0;
    readReg1 = '0;
    readReg2 = '0;
    inData = '0;
    @(posedge clk);
    #1;
    // Reset with a write attempt that must be ignored.
    drive(0, 1, 5'd3, 32'h1111_1111, 0, 0, 32'h4758_4236, 0, "rst");
    drive(1, 0, 0, 0, 5'd1, 5'd31, 32'h5376_2368, 1, "postRst");
    drive(1, 0, 0, 0, 5'd3, 5'd3, 32'hf827_f463, 1, "rstWrIgnored");
    // x0 stays zero.
    drive(1, 1, 5'd0, 32'd32, 0, 0, 32'hab47_a7a9, 1, "x0wr");
    drive(1, 0, 0, 0, 5'd0, 5'd0, 32'h8000_0000, 1, "x0rd");
    // Writes to x31 and x29.
    drive(1, 1, 5'd31, 32'd32, 5'd31, 5'd29, 32'h7fff_ffff, 1, "w31");
    drive(1, 1, 5'd29, 32'd32, 5'd31, 5'd29, 32'hffff_ffff, 1, "w29");
    drive(1, 0, 0, 0, 5'd31, 5'd29, 32'h0, 1, "rd31_29");
    drive(1, 0, 0, 0, 5'd31, 5'd1, 32'h1, 1, "rd31_1");
    // Write disabled.
    drive(1, 0, 5'd5, 32'hdead, 5'd5, 5'd5, 32'h8000_0001, 1, "weOff");
    drive(1, 0, 0, 0, 5'd5, 5'd5, 32'h0, 1, "weOffRd");
    // Read during write to same index: old value, then new.
    drive(1, 1, 5'd7, 32'hbeef, 5'd7, 5'd7, 32'h0, 1, "x7a");
    drive(1, 1, 5'd7, 32'h1234, 5'd7, 5'd7, 32'h0, 1, "x7old");
    drive(1, 0, 0, 0, 5'd7, 5'd7, 32'h0, 1, "x7new");
    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) != 0), $urandom_range(0, 1),
            5'($urandom), $urandom, 5'($urandom), 5'($urandom),
            $urandom, 1, "rand");
    end
    drive(1, 0, 0, 0, 0, 0, 32'h0, 1, "idle");
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
